iob_cache_be_arbiter: RTL and testbench



---
 rtl/iob_cache_be_arbiter_pkg.sv | 25 ++
 rtl/iob_cache_be_arb_sel.sv | 28 ++
 rtl/iob_cache_be_arbiter.sv | 154 +++++++++++++++
 tb/tb_iob_cache_be_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_be_arbiter_pkg.sv
// Shared definitions for the cache back-end arbiter: FSM encodings, grant bit
// positions and the one-hot grant decode.
package iob_cache_be_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_WR = 2'd1,
      GNT_RD = 2'd2
   } arb_state_t;

   localparam int unsigned WR = 0;
   localparam int unsigned RD = 1;

   function automatic logic [1:0] grant_vec(input arb_state_t st);
      logic [1:0] g;
      g = 2'b00;
      case (st)
         GNT_WR:  g[WR] = 1'b1;
         GNT_RD:  g[RD] = 1'b1;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/iob_cache_be_arb_sel.sv
// Combinational winner selection between the write and read channels.
// rd_pri decides a conflict: high lets the read win, low lets the write win.
module iob_cache_be_arb_sel (
   input  logic wr_valid,
   input  logic rd_valid,
   input  logic rd_pri,
   output logic win_wr,
   output logic win_rd
);

   // A lone requester always wins; rd_pri only matters when both ask.
   always_comb begin
      win_wr = 1'b0;
      win_rd = 1'b0;
      if (wr_valid && rd_valid) begin
         win_rd = rd_pri;
         win_wr = !rd_pri;
      end else if (wr_valid) begin
         win_wr = 1'b1;
      end else if (rd_valid) begin
         win_rd = 1'b1;
      end else begin
         win_wr = 1'b0;
         win_rd = 1'b0;
      end
   end

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Shares the native back-end memory port between the write and read channels.
// Define IOB_CACHE_BE_ARB_RR_EN for round-robin instead of write priority.
module iob_cache_be_arbiter
   import iob_cache_be_arbiter_pkg::*;
#(
   parameter int BE_ADDR_W     = 24,
   parameter int BE_DATA_W     = 32,
   parameter int MAX_WR_STREAK = 4,
   parameter int BE_NBYTES     = BE_DATA_W / 8,
   parameter int STREAK_W      = $clog2(MAX_WR_STREAK + 1)
) (
   input  logic                 clk_i,
   input  logic                 arst_n_i,
   input  logic                 wr_valid_i,
   input  logic [BE_ADDR_W-1:0] wr_addr_i,
   input  logic [BE_DATA_W-1:0] wr_wdata_i,
   input  logic [BE_NBYTES-1:0] wr_wstrb_i,
   output logic                 wr_ack_o,
   input  logic                 rd_valid_i,
   input  logic [BE_ADDR_W-1:0] rd_addr_i,
   output logic [BE_DATA_W-1:0] rd_rdata_o,
   output logic                 rd_ack_o,
   output logic                 mem_valid_o,
   output logic [BE_ADDR_W-1:0] mem_addr_o,
   output logic [BE_DATA_W-1:0] mem_wdata_o,
   output logic [BE_NBYTES-1:0] mem_wstrb_o,
   input  logic [BE_DATA_W-1:0] mem_rdata_i,
   input  logic                 mem_ack_i,
   output logic [1:0]           grant_o
);

   arb_state_t state_r;
   logic       free_s;
   logic       abort_s;
   logic       rd_pri_s;
   logic       win_wr_s;
   logic       win_rd_s;

`ifdef IOB_CACHE_BE_ARB_RR_EN
   logic last_rd_r;

   assign rd_pri_s = !last_rd_r;
`else
   logic [STREAK_W-1:0] streak_r;
   logic                streak_full_s;

   assign streak_full_s = (streak_r == STREAK_W'(MAX_WR_STREAK));
   assign rd_pri_s      = streak_full_s;
`endif

   iob_cache_be_arb_sel u_sel (
      .wr_valid (wr_valid_i),
      .rd_valid (rd_valid_i),
      .rd_pri   (rd_pri_s),
      .win_wr   (win_wr_s),
      .win_rd   (win_rd_s)
   );

   // Port is free to re-arbitrate in IDLE or on the owner's last acked beat;
   // an owner dropping valid without an ack aborts straight to IDLE.
   always_comb begin
      free_s  = 1'b0;
      abort_s = 1'b0;
      case (state_r)
         IDLE: begin
            free_s = 1'b1;
         end
         GNT_WR: begin
            free_s  = mem_ack_i && !wr_valid_i;
            abort_s = !mem_ack_i && !wr_valid_i;
         end
         GNT_RD: begin
            free_s  = mem_ack_i && !rd_valid_i;
            abort_s = !mem_ack_i && !rd_valid_i;
         end
         default: begin
            free_s  = 1'b1;
            abort_s = 1'b0;
         end
      endcase
   end

   // Grant FSM together with the fairness state it updates on each grant.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_r <= IDLE;
`ifdef IOB_CACHE_BE_ARB_RR_EN
         last_rd_r <= 1'b1;
`else
         streak_r <= {STREAK_W{1'b0}};
`endif
      end else if (free_s) begin
         if (win_wr_s) begin
            state_r <= GNT_WR;
`ifdef IOB_CACHE_BE_ARB_RR_EN
            last_rd_r <= 1'b0;
`else
            if (rd_valid_i) begin
               streak_r <= streak_full_s ? streak_r : streak_r + STREAK_W'(1);
            end else begin
               streak_r <= {STREAK_W{1'b0}};
            end
`endif
         end else if (win_rd_s) begin
            state_r <= GNT_RD;
`ifdef IOB_CACHE_BE_ARB_RR_EN
            last_rd_r <= 1'b1;
`else
            streak_r <= {STREAK_W{1'b0}};
`endif
         end else begin
            state_r <= IDLE;
         end
      end else if (abort_s) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_r;
      end
   end

   // Steer the memory port from the registered grant; no path from
   // mem_ack_i to mem_valid_o other than through the requester's valid.
   always_comb begin
      mem_valid_o = 1'b0;
      mem_addr_o  = {BE_ADDR_W{1'b0}};
      mem_wdata_o = {BE_DATA_W{1'b0}};
      mem_wstrb_o = {BE_NBYTES{1'b0}};
      wr_ack_o    = 1'b0;
      rd_ack_o    = 1'b0;
      case (state_r)
         GNT_WR: begin
            mem_valid_o = wr_valid_i;
            mem_addr_o  = wr_addr_i;
            mem_wdata_o = wr_wdata_i;
            mem_wstrb_o = wr_wstrb_i;
            wr_ack_o    = mem_ack_i;
         end
         GNT_RD: begin
            mem_valid_o = rd_valid_i;
            mem_addr_o  = rd_addr_i;
            rd_ack_o    = mem_ack_i;
         end
         default: begin
            mem_valid_o = 1'b0;
            wr_ack_o    = 1'b0;
            rd_ack_o    = 1'b0;
         end
      endcase
   end

   assign rd_rdata_o = mem_rdata_i;
   assign grant_o    = grant_vec(state_r);

endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// Self-checking bench for iob_cache_be_arbiter: directed scenarios followed by
// random traffic, all checked each cycle against a transaction-level model.
module tb_iob_cache_be_arbiter;

   localparam int AW   = 24;
   localparam int DW   = 32;
   localparam int MAXS = 4;
   localparam int NB   = DW / 8;

   logic          clk_i = 1'b0;
   logic          arst_n_i;
   logic          wr_valid_i;
   logic [AW-1:0] wr_addr_i;
   logic [DW-1:0] wr_wdata_i;
   logic [NB-1:0] wr_wstrb_i;
   logic          wr_ack_o;
   logic          rd_valid_i;
   logic [AW-1:0] rd_addr_i;
   logic [DW-1:0] rd_rdata_o;
   logic          rd_ack_o;
   logic          mem_valid_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [NB-1:0] mem_wstrb_o;
   logic [DW-1:0] mem_rdata_i;
   logic          mem_ack_i;
   logic [1:0]    grant_o;

   iob_cache_be_arbiter #(
      .BE_ADDR_W(AW), .BE_DATA_W(DW), .MAX_WR_STREAK(MAXS)
   ) dut (
      .clk_i(clk_i), .arst_n_i(arst_n_i),
      .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_wdata_i(wr_wdata_i),
      .wr_wstrb_i(wr_wstrb_i), .wr_ack_o(wr_ack_o),
      .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i), .rd_rdata_o(rd_rdata_o),
      .rd_ack_o(rd_ack_o),
      .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_wstrb_o(mem_wstrb_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .grant_o(grant_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   // Model: who owns the port (0 none, 1 write, 2 read) and fairness history.
   int m_owner;
   int m_streak;
   bit m_last_rd;
   int wr_ack_cnt;
   int rd_ack_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner   = 0;
      m_streak  = 0;
      m_last_rd = 1'b1;
   endtask

   // Pick a winner among the current requesters and record the grant.
   task automatic model_arbitrate(input bit wr, input bit rd);
      int win;
      if (wr && rd) begin
`ifdef IOB_CACHE_BE_ARB_RR_EN
         win = m_last_rd ? 1 : 2;
`else
         win = (m_streak == MAXS) ? 2 : 1;
`endif
      end else if (wr) begin
         win = 1;
      end else if (rd) begin
         win = 2;
      end else begin
         win = 0;
      end
      if (win == 1) begin
         m_streak  = rd ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
         m_last_rd = 1'b0;
      end else if (win == 2) begin
         m_streak  = 0;
         m_last_rd = 1'b1;
      end
      m_owner = win;
   endtask

   // One clock: check outputs at the falling edge, advance the model, then
   // return just after the rising edge so the caller can drive new inputs.
   task automatic cyc();
      logic          own_v;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      logic [NB-1:0] e_wstrb;
      @(negedge clk_i);
      own_v   = (m_owner == 1) ? wr_valid_i : (m_owner == 2) ? rd_valid_i : 1'b0;
      e_addr  = (m_owner == 1) ? wr_addr_i : (m_owner == 2) ? rd_addr_i : '0;
      e_wdata = (m_owner == 1) ? wr_wdata_i : '0;
      e_wstrb = (m_owner == 1) ? wr_wstrb_i : '0;
      chk("mem_valid", mem_valid_o, own_v);
      chk("mem_addr",  mem_addr_o,  e_addr);
      chk("mem_wdata", mem_wdata_o, e_wdata);
      chk("mem_wstrb", mem_wstrb_o, e_wstrb);
      chk("wr_ack",    wr_ack_o,    (m_owner == 1) && mem_ack_i);
      chk("rd_ack",    rd_ack_o,    (m_owner == 2) && mem_ack_i);
      chk("rd_rdata",  rd_rdata_o,  mem_rdata_i);
      chk("grant",     grant_o,     (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00);
      wr_ack_cnt += int'(wr_ack_o);
      rd_ack_cnt += int'(rd_ack_o);
      if (m_owner == 0 || (mem_ack_i && !own_v)) begin
         model_arbitrate(wr_valid_i, rd_valid_i);
      end else if (!own_v) begin
         m_owner = 0;
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [DW-1:0] fill [4];
      int wr_beats;
      int rd_beats;
      fill[0] = 32'h11; fill[1] = 32'h22; fill[2] = 32'h33; fill[3] = 32'h44;
      arst_n_i = 1'b0;
      wr_valid_i = 1'b0; wr_addr_i = '0; wr_wdata_i = '0; wr_wstrb_i = '0;
      rd_valid_i = 1'b0; rd_addr_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
      model_reset();
      #12;
      chk("rst_mem_valid", mem_valid_o, 1'b0);
      chk("rst_grant",     grant_o,     2'b00);
      chk("rst_acks",      {wr_ack_o, rd_ack_o}, 2'b00);
      chk("rst_wstrb",     mem_wstrb_o, 4'h0);
      @(negedge clk_i);
      arst_n_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Lone single-beat write, acked on the second granted cycle
      wr_ack_cnt = 0;
      wr_valid_i = 1'b1; wr_addr_i = 24'h000100; wr_wdata_i = 32'hDEADBEEF; wr_wstrb_i = 4'hF;
      cyc();
      chk("wr_latency", mem_valid_o, 1'b1);
      chk("wr_grant",   grant_o,     2'b01);
      chk("wr_strb",    mem_wstrb_o, 4'hF);
      chk("wr_addr",    mem_addr_o,  24'h000100);
      cyc();
      mem_ack_i = 1'b1; wr_valid_i = 1'b0;
      cyc();
      mem_ack_i = 1'b0;
      #1;
      chk("wr_ack_once", wr_ack_cnt, 1);
      chk("wr_to_idle",  grant_o,    2'b00);

      // Lone 4-beat read fill
      rd_valid_i = 1'b1; rd_addr_i = 24'h000200;
      cyc();
      for (int b = 0; b < 4; b++) begin
         mem_rdata_i = fill[b]; mem_ack_i = 1'b1; rd_valid_i = (b < 3);
         #1;
         chk("fill_grant", grant_o,     2'b10);
         chk("fill_ack",   rd_ack_o,    1'b1);
         chk("fill_data",  rd_rdata_o,  fill[b]);
         chk("fill_wstrb", mem_wstrb_o, 4'h0);
         cyc();
      end
      mem_ack_i = 1'b0;
      #1;
      chk("fill_to_idle", grant_o, 2'b00);

      // Simultaneous requests: write first, then a direct switch to read
      wr_valid_i = 1'b1; rd_valid_i = 1'b1;
      cyc();
      chk("both_wr_first", grant_o, 2'b01);
      mem_ack_i = 1'b1; wr_valid_i = 1'b0;
      cyc();
      chk("both_rd_direct", grant_o, 2'b10);
      rd_valid_i = 1'b0;
      cyc();
      mem_ack_i = 1'b0;

`ifndef IOB_CACHE_BE_ARB_RR_EN
      // Streak limit: conflicts re-arise via aborted writes while a read waits
      rd_valid_i = 1'b1;
      for (int k = 0; k < MAXS; k++) begin
         wr_valid_i = 1'b1;
         cyc();
         chk("streak_wr", grant_o, 2'b01);
         wr_valid_i = 1'b0;
         cyc();
         chk("streak_abort", grant_o, 2'b00);
      end
      wr_valid_i = 1'b1;
      cyc();
      chk("streak_rd", grant_o, 2'b10);
      mem_ack_i = 1'b1; rd_valid_i = 1'b0;
      cyc();
      chk("streak_wr_resume", grant_o, 2'b01);
      wr_valid_i = 1'b0;
      cyc();
      mem_ack_i = 1'b0;
`endif

      // 8-beat write-back burst; read arrives at beat 2 and must wait
      wr_valid_i = 1'b1; wr_wstrb_i = 4'hA;
      cyc();
      for (int b = 0; b < 8; b++) begin
         mem_ack_i = 1'b1; wr_valid_i = (b < 7);
         if (b == 2) rd_valid_i = 1'b1;
         #1;
         chk("burst_hold", grant_o, 2'b01);
         cyc();
      end
      mem_ack_i = 1'b0;
      #1;
      chk("burst_then_rd", grant_o, 2'b10);
      mem_ack_i = 1'b1; rd_valid_i = 1'b0;
      cyc();
      mem_ack_i = 1'b0;

      // Asynchronous reset during beat 2 of a burst
      wr_valid_i = 1'b1;
      cyc();
      mem_ack_i = 1'b1;
      cyc();
      #2;
      arst_n_i = 1'b0;
      #1;
      chk("arst_mem_valid", mem_valid_o, 1'b0);
      chk("arst_grant",     grant_o,     2'b00);
      wr_valid_i = 1'b0; mem_ack_i = 1'b0;
      model_reset();
      @(negedge clk_i);
      arst_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      rd_valid_i = 1'b1;
      cyc();
      chk("post_rst_grant", grant_o,     2'b10);
      chk("post_rst_valid", mem_valid_o, 1'b1);
      mem_ack_i = 1'b1; rd_valid_i = 1'b0;
      cyc();
      mem_ack_i = 1'b0;

      // Both channels keep requesting single beats: grants alternate
      wr_valid_i = 1'b1; rd_valid_i = 1'b1;
      cyc();
      for (int k = 0; k < 4; k++) begin
         chk("alternate", grant_o, (k % 2 == 0) ? 2'b01 : 2'b10);
         wr_valid_i = (k % 2 == 1); rd_valid_i = (k % 2 == 0); mem_ack_i = 1'b1;
         cyc();
      end
      wr_valid_i = 1'b0; rd_valid_i = 1'b0; mem_ack_i = 1'b0;
      cyc();
      cyc();

      // Random bursts, ack gaps, aborts and stray acks
      wr_beats = 0;
      rd_beats = 0;
      for (int i = 0; i < 3000; i++) begin
         if (wr_beats == 0 && m_owner != 1 && $urandom_range(0, 3) == 0) wr_beats = $urandom_range(1, 8);
         if (rd_beats == 0 && m_owner != 2 && $urandom_range(0, 3) == 0) rd_beats = $urandom_range(1, 8);
         mem_ack_i = ($urandom_range(0, 2) != 0);
         if (m_owner == 1 && wr_beats > 0) begin
            if (mem_ack_i) wr_beats--;
            else if ($urandom_range(0, 24) == 0) wr_beats = 0;
         end
         if (m_owner == 2 && rd_beats > 0) begin
            if (mem_ack_i) rd_beats--;
            else if ($urandom_range(0, 24) == 0) rd_beats = 0;
         end
         wr_valid_i  = (wr_beats > 0);
         rd_valid_i  = (rd_beats > 0);
         wr_addr_i   = AW'($urandom);
         wr_wdata_i  = $urandom;
         wr_wstrb_i  = NB'($urandom);
         rd_addr_i   = AW'($urandom);
         mem_rdata_i = $urandom;
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
